// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, TX/RX FSM state encodings and a parity helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Unused upper bits must be zero-padded by the caller.
  function automatic logic parity_of(input logic [8:0] d, input int mode);
    return (^d) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead RX FIFO; a push while full with no pop is dropped and reported on drop.
module uart_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_n;
  logic             do_push_s, do_pop_s, full_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign do_pop_s  = pop && (count_r != '0);
  assign do_push_s = push && (!full_s || do_pop_s);
  assign drop      = push && !do_push_s;
  assign valid     = (count_r != '0);
  assign count     = count_r;

  always_comb begin
    count_n = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_n = count_r + CNT_W'(1);
      2'b01:   count_n = count_r - CNT_W'(1);
      default: count_n = count_r;
    endcase
  end

  always_comb begin
    if (valid) begin
      head = mem[rd_ptr_r];
    end else begin
      head = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem[wr_ptr_r] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_n;
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// UART transmitter and receiver with a show-ahead RX FIFO and sticky frame/overflow flags.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          tx_done,
  input  logic                          rx_serial,
  input  logic                          rx_read,
  output logic                          rx_valid,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_frame_err,
  output logic                          rx_overflow,
  input  logic                          err_clear
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);

  tx_state_t tx_state_r, tx_state_n;
  logic [CW-1:0] tx_cnt_r, tx_cnt_n;
  logic [BW-1:0] tx_bit_r, tx_bit_n, tx_bit_next_s;
  logic [DATA_BITS-1:0] tx_data_r, tx_data_n;
  logic tx_serial_r, tx_serial_n, tx_done_r, tx_done_n;

  assign tx_bit_next_s = tx_bit_r + BW'(1);
  assign tx_ready  = (tx_state_r == TX_IDLE);
  assign tx_serial = tx_serial_r;
  assign tx_done   = tx_done_r;

  always_comb begin
    tx_state_n  = tx_state_r;
    tx_cnt_n    = tx_cnt_r + CW'(1);
    tx_bit_n    = tx_bit_r;
    tx_data_n   = tx_data_r;
    tx_serial_n = tx_serial_r;
    tx_done_n   = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        tx_cnt_n    = '0;
        tx_serial_n = 1'b1;
        if (tx_valid) begin
          tx_data_n   = tx_data;
          tx_serial_n = 1'b0;
          tx_state_n  = TX_START;
        end else begin
          tx_state_n  = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt_r == BIT_END) begin
          tx_cnt_n    = '0;
          tx_bit_n    = '0;
          tx_serial_n = tx_data_r[0];
          tx_state_n  = TX_DATA;
        end else begin
          tx_state_n  = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r != BIT_END) begin
          tx_state_n = TX_DATA;
        end else if (tx_bit_r != LAST_BIT) begin
          tx_cnt_n    = '0;
          tx_bit_n    = tx_bit_next_s;
          tx_serial_n = tx_data_r[tx_bit_next_s];
        end else if (HAS_PARITY) begin
          tx_cnt_n    = '0;
          tx_serial_n = parity_of(9'(tx_data_r), PARITY_MODE);
          tx_state_n  = TX_PARITY;
        end else begin
          tx_cnt_n    = '0;
          tx_serial_n = 1'b1;
          tx_state_n  = TX_STOP;
        end
      end
      TX_PARITY: begin
        if (tx_cnt_r == BIT_END) begin
          tx_cnt_n    = '0;
          tx_serial_n = 1'b1;
          tx_state_n  = TX_STOP;
        end else begin
          tx_state_n  = TX_PARITY;
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == BIT_END) begin
          tx_cnt_n   = '0;
          tx_done_n  = 1'b1;
          tx_state_n = TX_IDLE;
        end else begin
          tx_state_n = TX_STOP;
        end
      end
      default: begin
        tx_cnt_n    = '0;
        tx_serial_n = 1'b1;
        tx_state_n  = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_r  <= TX_IDLE;
      tx_cnt_r    <= '0;
      tx_bit_r    <= '0;
      tx_data_r   <= '0;
      tx_serial_r <= 1'b1;
      tx_done_r   <= 1'b0;
    end else begin
      tx_state_r  <= tx_state_n;
      tx_cnt_r    <= tx_cnt_n;
      tx_bit_r    <= tx_bit_n;
      tx_data_r   <= tx_data_n;
      tx_serial_r <= tx_serial_n;
      tx_done_r   <= tx_done_n;
    end
  end

  rx_state_t rx_state_r, rx_state_n;
  logic [1:0] rx_sync_r;
  logic [CW-1:0] rx_cnt_r, rx_cnt_n;
  logic [BW-1:0] rx_bit_r, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift_r, rx_shift_n;
  logic rx_perr_r, rx_perr_n, rx_push_r, rx_push_n, rx_s, ferr_set_s;
  logic ferr_r, ovf_r, fifo_drop_s;
  logic [DATA_BITS:0] fifo_head_s;

  assign rx_s = rx_sync_r[1];

  always_comb begin
    rx_state_n = rx_state_r;
    rx_cnt_n   = rx_cnt_r + CW'(1);
    rx_bit_n   = rx_bit_r;
    rx_shift_n = rx_shift_r;
    rx_perr_n  = rx_perr_r;
    rx_push_n  = 1'b0;
    ferr_set_s = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_s) rx_state_n = RX_START;
        else       rx_state_n = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt_r == HALF_END) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_perr_n  = 1'b0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_state_n = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_END) begin
          rx_cnt_n             = '0;
          rx_shift_n[rx_bit_r] = rx_s;
          if (rx_bit_r != LAST_BIT) rx_bit_n   = rx_bit_r + BW'(1);
          else if (HAS_PARITY)      rx_state_n = RX_PARITY;
          else                      rx_state_n = RX_STOP;
        end else begin
          rx_state_n = RX_DATA;
        end
      end
      RX_PARITY: begin
        if (rx_cnt_r == BIT_END) begin
          rx_cnt_n   = '0;
          rx_perr_n  = rx_s ^ parity_of(9'(rx_shift_r), PARITY_MODE);
          rx_state_n = RX_STOP;
        end else begin
          rx_state_n = RX_PARITY;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r != BIT_END) begin
          rx_state_n = RX_STOP;
        end else if (rx_s) begin
          rx_cnt_n   = '0;
          rx_push_n  = 1'b1;
          rx_state_n = RX_IDLE;
        end else begin
          rx_cnt_n   = '0;
          ferr_set_s = 1'b1;
          rx_state_n = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_n = '0;
        if (rx_s) rx_state_n = RX_IDLE;
        else      rx_state_n = RX_WAIT_HIGH;
      end
      default: begin
        rx_cnt_n   = '0;
        rx_state_n = RX_IDLE;
      end
    endcase
  end

  // Synchroniser idles high so reset release never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_sync_r  <= 2'b11;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= '0;
      rx_bit_r   <= '0;
      rx_shift_r <= '0;
      rx_perr_r  <= 1'b0;
      rx_push_r  <= 1'b0;
      ferr_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      rx_sync_r  <= {rx_sync_r[0], rx_serial};
      rx_state_r <= rx_state_n;
      rx_cnt_r   <= rx_cnt_n;
      rx_bit_r   <= rx_bit_n;
      rx_shift_r <= rx_shift_n;
      rx_perr_r  <= rx_perr_n;
      rx_push_r  <= rx_push_n;
      ferr_r     <= ferr_set_s  ? 1'b1 : (err_clear ? 1'b0 : ferr_r);
      ovf_r      <= fifo_drop_s ? 1'b1 : (err_clear ? 1'b0 : ovf_r);
    end
  end

  // Shift/parity registers are stable until the next start bit, so the push may lag a cycle.
  uart_rx_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push_r),
    .push_data ({rx_perr_r, rx_shift_r}),
    .pop       (rx_read),
    .head      (fifo_head_s),
    .valid     (rx_valid),
    .count     (rx_count),
    .drop      (fifo_drop_s)
  );

  assign rx_data       = fifo_head_s[DATA_BITS-1:0];
  assign rx_parity_err = fifo_head_s[DATA_BITS];
  assign rx_frame_err  = ferr_r;
  assign rx_overflow   = ovf_r;

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench: 8N1 instance with a per-cycle TX/RX model, plus an even-parity RX instance.
module tb_uart_transceiver;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic tx_valid0, tx_ready0, tx_serial0, tx_done0, rx_serial0, rx_read0;
  logic rx_valid0, rx_parity_err0, rx_frame_err0, rx_overflow0, err_clear0;
  logic [7:0] tx_data0, rx_data0;
  logic [2:0] rx_count0;

  logic tx_valid1, tx_ready1, tx_serial1, tx_done1, rx_serial1, rx_read1;
  logic rx_valid1, rx_parity_err1, rx_frame_err1, rx_overflow1, err_clear1;
  logic [7:0] tx_data1, rx_data1;
  logic [2:0] rx_count1;

  uart_transceiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .FIFO_DEPTH(4)) dut0 (
    .clock(clk), .reset(rst_n), .tx_valid(tx_valid0), .tx_data(tx_data0), .tx_ready(tx_ready0),
    .tx_serial(tx_serial0), .tx_done(tx_done0), .rx_serial(rx_serial0), .rx_read(rx_read0),
    .rx_valid(rx_valid0), .rx_data(rx_data0), .rx_parity_err(rx_parity_err0), .rx_count(rx_count0),
    .rx_frame_err(rx_frame_err0), .rx_overflow(rx_overflow0), .err_clear(err_clear0));

  uart_transceiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .FIFO_DEPTH(4)) dut1 (
    .clock(clk), .reset(rst_n), .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_ready(tx_ready1),
    .tx_serial(tx_serial1), .tx_done(tx_done1), .rx_serial(rx_serial1), .rx_read(rx_read1),
    .rx_valid(rx_valid1), .rx_data(rx_data1), .rx_parity_err(rx_parity_err1), .rx_count(rx_count1),
    .rx_frame_err(rx_frame_err1), .rx_overflow(rx_overflow1), .err_clear(err_clear1));

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // TX model: each accepted word becomes a queue of per-cycle {done, line} items.
  logic [1:0] txq[$];
  logic m_ser = 1'b1, m_done = 1'b0, m_ready = 1'b1, acc = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      txq.delete();
      m_ser = 1'b1; m_done = 1'b0; m_ready = 1'b1; acc = 1'b0;
    end else begin
      acc = 1'b0;
      if (m_ready && tx_valid0) begin
        for (int k = 0; k < 10; k++) begin
          logic b;
          b = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : tx_data0[k-1];
          repeat (CPB) txq.push_back({1'b0, b});
        end
        txq.push_back(2'b11);
        acc = 1'b1;
      end
      if (txq.size() > 0) {m_done, m_ser} = txq.pop_front();
      else                {m_done, m_ser} = 2'b01;
      m_ready = (txq.size() == 0) || m_done;
    end
  end

  // RX model for dut0: bounded queue of received words and sticky flags.
  logic [8:0] mq[$];
  logic mferr = 1'b0, movf = 1'b0, rx_chk = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("tx_serial", 32'(tx_serial0), 32'(m_ser));
      check("tx_ready",  32'(tx_ready0),  32'(m_ready));
      check("tx_done",   32'(tx_done0),   32'(m_done));
      if (rx_chk) begin
        logic [8:0] h;
        h = (mq.size() > 0) ? mq[0] : 9'h000;
        check("rx_valid",     32'(rx_valid0),      32'(mq.size() > 0));
        check("rx_count",     32'(rx_count0),      32'(mq.size()));
        check("rx_data",      32'(rx_data0),       32'(h[7:0]));
        check("rx_parity",    32'(rx_parity_err0), 32'(h[8]));
        check("rx_frame_err", 32'(rx_frame_err0),  32'(mferr));
        check("rx_overflow",  32'(rx_overflow0),   32'(movf));
      end
    end
  end

  task automatic send_tx(input logic [7:0] d, input logic keep);
    @(negedge clk);
    tx_valid0 = 1'b1;
    tx_data0  = d;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (acc) break;
    end
    check("tx_accept", 32'(acc), 32'h1);
    tx_valid0 = keep;
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_serial0 = v;
    else          rx_serial1 = v;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic use_par,
                            input logic pbit, input logic stop, input logic rd);
    logic [10:0] f;
    int n;
    f = 11'h000;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    n = 9;
    if (use_par) begin f[9] = pbit; n = 10; end
    f[n] = stop;
    n = n + 1;
    if (sel == 0) rx_chk = 1'b0;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      set_line(sel, f[k]);
      repeat (CPB) @(negedge clk);
    end
    set_line(sel, 1'b1);
    @(negedge clk);
    if (sel == 0) rx_read0 = rd;
    @(posedge clk); #1;
    rx_read0 = 1'b0;
    if (sel == 0) begin
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (stop) begin
        if (mq.size() < 4) mq.push_back({1'b0, d});
        else               movf = 1'b1;
      end else begin
        mferr = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
    if (sel == 0) rx_chk = 1'b1;
  endtask

  task automatic pop(input int sel);
    @(negedge clk);
    if (sel == 0) rx_read0 = 1'b1;
    else          rx_read1 = 1'b1;
    @(posedge clk); #1;
    rx_read0 = 1'b0;
    rx_read1 = 1'b0;
    if (sel == 0 && mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic clear_errs();
    @(negedge clk);
    err_clear0 = 1'b1;
    @(posedge clk); #1;
    err_clear0 = 1'b0;
    mferr = 1'b0;
    movf  = 1'b0;
  endtask

  logic [9:0] pat;

  initial begin
    rst_n = 1'b0;
    tx_valid0 = 1'b0; tx_data0 = 8'h00; rx_serial0 = 1'b1; rx_read0 = 1'b0; err_clear0 = 1'b0;
    tx_valid1 = 1'b0; tx_data1 = 8'h00; rx_serial1 = 1'b1; rx_read1 = 1'b0; err_clear1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_serial", 32'(tx_serial0), 32'h1);
    check("rst_tx_ready",  32'(tx_ready0),  32'h1);
    check("rst_tx_done",   32'(tx_done0),   32'h0);
    check("rst_rx_valid",  32'(rx_valid0),  32'h0);
    check("rst_rx_count",  32'(rx_count0),  32'h0);
    check("rst_rx_data",   32'(rx_data0),   32'h0);
    check("rst_ferr",      32'(rx_frame_err0), 32'h0);
    check("rst_ovf",       32'(rx_overflow0),  32'h0);
    rst_n = 1'b1;
    rx_chk = 1'b1;
    repeat (2) @(negedge clk);

    // 0x41 8N1: start, 1,0,0,0,0,0,1,0, stop; tx_done on cycle 41
    pat = 10'b1010000010;
    send_tx(8'h41, 1'b0);
    for (int c = 1; c <= 41; c++) begin
      @(negedge clk);
      if (c <= 40) check("tx41_bit", 32'(tx_serial0), 32'(pat[(c-1)/CPB]));
      check("tx41_done", 32'(tx_done0), 32'(c == 41));
    end
    repeat (3) @(negedge clk);

    send_tx(8'h3C, 1'b1);
    send_tx(8'hC3, 1'b0);
    repeat (45) @(negedge clk);

    // 0x31 has three ones, so even parity bit is 1
    send_frame(1, 8'h31, 1'b1, 1'b1, 1'b1, 1'b0);
    check("par_ok_valid", 32'(rx_valid1), 32'h1);
    check("par_ok_data",  32'(rx_data1),  32'h31);
    check("par_ok_perr",  32'(rx_parity_err1), 32'h0);
    pop(1);
    send_frame(1, 8'h31, 1'b1, 1'b0, 1'b1, 1'b0);
    check("par_bad_data", 32'(rx_data1), 32'h31);
    check("par_bad_perr", 32'(rx_parity_err1), 32'h1);
    pop(1);
    @(negedge clk);
    check("par_empty", 32'(rx_valid1), 32'h0);

    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ferr_count", 32'(rx_count0), 32'h0);
    check("ferr_set",   32'(rx_frame_err0), 32'h1);
    clear_errs();
    @(negedge clk);
    check("ferr_clear", 32'(rx_frame_err0), 32'h0);

    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovf_count", 32'(rx_count0), 32'h4);
    check("ovf_flag",  32'(rx_overflow0), 32'h1);
    check("ovf_head",  32'(rx_data0), 32'h01);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_read", 32'(rx_data0), 32'(i));
      pop(0);
    end
    @(negedge clk);
    check("ovf_empty", 32'(rx_valid0), 32'h0);
    pop(0);
    @(negedge clk);
    check("empty_read_count", 32'(rx_count0), 32'h0);
    clear_errs();

    for (int i = 1; i <= 4; i++) send_frame(0, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'h15, 1'b0, 1'b0, 1'b1, 1'b1);
    check("full_rw_count", 32'(rx_count0), 32'h4);
    check("full_rw_ovf",   32'(rx_overflow0), 32'h0);
    for (int i = 2; i <= 5; i++) begin
      check("full_rw_read", 32'(rx_data0), 32'(8'h10 + i));
      pop(0);
    end

    send_tx(8'h96, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_serial", 32'(tx_serial0), 32'h1);
    check("rst_mid_ready",  32'(tx_ready0),  32'h1);
    check("rst_mid_done",   32'(tx_done0),   32'h0);
    mq.delete(); mferr = 1'b0; movf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_done", 32'(tx_done0), 32'h0);
    end
    rst_n = 1'b1;
    send_tx(8'h41, 1'b0);
    for (int c = 1; c <= 41; c++) begin
      @(negedge clk);
      if (c <= 40) check("post_rst_bit", 32'(tx_serial0), 32'(pat[(c-1)/CPB]));
    end
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 Parameters SHALL be exactly:
- CLKS_PER_BIT, default 5208: clocks per bit (50 MHz / 9600 baud); minimum 4.
- DATA_BITS, default 8: data bits per frame, 5..9.
- PARITY_MODE, default 0: 0 none, 1 even, 2 odd.
- FIFO_DEPTH, default 4: RX FIFO words; power of 2, at least 2.

REQ-002 Ports SHALL be exactly:
- clock  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_valid  in  1  a TX word is offered.
- tx_data  in  DATA_BITS  word to transmit.
- tx_ready  out  1  transmitter can accept a word.
- tx_serial  out  1  serial line out; idle high.
- tx_done  out  1  one-cycle pulse at end of a frame.
- rx_serial  in  1  serial line in; asynchronous to clock.
- rx_read  in  1  pop the RX FIFO head.
- rx_valid  out  1  RX FIFO not empty.
- rx_data  out  DATA_BITS  RX FIFO head word.
- rx_parity_err  out  1  parity error flag of the head word.
- rx_count  out  clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
- rx_frame_err  out  1  sticky: a stop bit was sampled low.
- rx_overflow  out  1  sticky: a word was dropped because the FIFO was full.
- err_clear  in  1  clears both sticky flags.

Function
REQ-003 The TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; it SHALL skip PARITY when PARITY_MODE is 0.
REQ-004 tx_ready SHALL be 1 only in IDLE; a word SHALL be accepted on a clock where tx_valid and tx_ready are both 1, and tx_data SHALL be latched on that clock.
REQ-005 The frame SHALL start the cycle after acceptance: start bit 0, then data LSB first, then the parity bit if enabled, then stop bit 1; each bit SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-006 The parity bit SHALL be the XOR of the data bits for even parity and its inverse for odd parity.
REQ-007 tx_done SHALL pulse for one cycle, with tx_ready 1, in the cycle after the stop bit ends; a word offered in that cycle SHALL be accepted, giving back-to-back frames with no extra idle time.
REQ-008 rx_serial SHALL pass through a 2-flop synchroniser; the RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-009 In IDLE, a synchronised 0 SHALL enter START.
- At CLKS_PER_BIT/2 the line SHALL be re-sampled; if it is 1, the FSM SHALL return to IDLE (glitch, no flag).
- Each later bit SHALL be sampled CLKS_PER_BIT cycles after the previous sample.
REQ-010 Stop bit sampled 1: the word and its parity-error bit SHALL be pushed into the FIFO the next cycle, and the FSM SHALL return to IDLE.
REQ-011 Stop bit sampled 0: no push; rx_frame_err SHALL set; the FSM SHALL enter WAIT_HIGH until the line is sampled 1.
REQ-012 FIFO behaviour:
- rx_read while empty SHALL be ignored.
- Push while full with no pop: the word SHALL be dropped and rx_overflow set.
- Push and pop on the same clock while full: both SHALL succeed, no overflow.
- Push and pop on the same clock while empty: the push SHALL succeed, count ends at 1.
REQ-013 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-014 The FIFO read SHALL be show-ahead: rx_data and rx_parity_err SHALL show the head word while rx_valid is 1, and both SHALL be 0 when the FIFO is empty.
REQ-015 err_clear SHALL clear the sticky flags on the next clock; a flag-setting event on that same clock SHALL win.

Reset
REQ-016 While reset is low, immediately:
- tx_serial 1, tx_ready 1, tx_done 0.
- Both FSMs in IDLE, all counters 0.
- FIFO empty: rx_valid 0, rx_count 0, rx_data 0.
- rx_frame_err 0, rx_overflow 0.
REQ-017 A reset during a frame SHALL abort the frame with no push and no tx_done; FIFO memory contents need not be reset.

Structure
REQ-018 A shared package uart_pkg SHALL hold the PARITY_MODE constants (PARITY_NONE, PARITY_EVEN, PARITY_ODD) and the TX and RX state encodings.
REQ-019 The RX FIFO SHALL be a sub-module, uart_rx_fifo, parameterised by width (DATA_BITS+1) and depth; the TX and RX FSMs SHALL stay in uart_transceiver.

Verification (bench at CLKS_PER_BIT=4)
REQ-020 TX 0x41, 8N1, accepted at cycle 0 -> tx_serial = 0,1,0,0,0,0,0,1,0,1, each held 4 cycles over cycles 1-40; tx_done at cycle 41.
REQ-021 RX 0x31 with even parity bit 1 -> rx_valid 1, rx_data 0x31, rx_parity_err 0; repeat with parity bit 0 -> rx_parity_err 1.
REQ-022 RX frame with stop bit 0 -> rx_count stays 0, rx_frame_err 1; err_clear pulse -> rx_frame_err 0.
REQ-023 Depth 4, five words 0x01-0x05 received with no reads -> rx_count 4, rx_overflow 1, rx_data 0x01; four reads -> 0x01-0x04, then rx_valid 0.
REQ-024 FIFO full, rx_read on the push cycle -> rx_count stays 4, rx_overflow 0.
REQ-025 reset low during a TX data bit -> tx_serial 1 immediately, tx_ready 1, no tx_done; after release, a new word transmits correctly.
